// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the Mult/Div sequencer: op kinds, FSM states, defaults.
package muldiv_defs;

  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_DIVM = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  localparam int DEF_TIMEOUT_CYCLES = 40;
  localparam int DEF_CNT_W          = 6;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_MULT_RUN = 3'd1,
    S_DIV_RUN  = 3'd2,
    S_WRITE    = 3'd3,
    S_ERR      = 3'd4
  } state_t;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Control-unit <-> sequencer bus, including the Mult/Div and HI/LO side signals.
interface muldiv_sequencer_if;
  logic       op_valid;
  logic [1:0] op_kind;
  logic       op_ready;
  logic       busy;
  logic       mult_start;
  logic       mult_end;
  logic       div_start;
  logic       div_end;
  logic       div_0_exception;
  logic       div_src;
  logic       div_or_mult;
  logic       high_write;
  logic       low_write;
  logic       done;
  logic       div_zero_err;
  logic       timeout_err;

  // Master: control unit plus the Mult/Div units driving requests and completions.
  modport master (
    output op_valid, op_kind, mult_end, div_end, div_0_exception,
    input  op_ready, busy, mult_start, div_start, div_src, div_or_mult,
           high_write, low_write, done, div_zero_err, timeout_err
  );

  // Slave: the sequencer itself.
  modport slave (
    input  op_valid, op_kind, mult_end, div_end, div_0_exception,
    output op_ready, busy, mult_start, div_start, div_src, div_or_mult,
           high_write, low_write, done, div_zero_err, timeout_err
  );
endinterface

// File: rtl/muldiv_watchdog.sv
// Run-length watchdog: clear on accept, count while running, flag the last allowed cycle.
module muldiv_watchdog #(
  parameter int TIMEOUT_CYCLES = 40,
  parameter int CNT_W          = 6
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic first,
  output logic expired
);

  logic [CNT_W-1:0] cnt;

  // Counter: clear has priority; the FSM leaves RUN at expiry so it never wraps.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + 1'b1;
  end

  assign first   = (cnt == '0);
  assign expired = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/muldiv_sequencer.sv
// Sequences Mult/Div start pulses and HI/LO commits; reports div-by-zero and timeout.
module muldiv_sequencer
  import muldiv_defs::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic clock,
  input  logic reset,
  muldiv_sequencer_if.slave bus
);

  state_t     state, state_nxt;
  logic [1:0] kind_q;
  logic       zero_q, zero_nxt;
  logic       accept;
  logic       wd_clr, wd_en, wd_first, wd_expired;

  muldiv_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_wd (
    .clock  (clock),
    .reset  (reset),
    .clr    (wd_clr),
    .en     (wd_en),
    .first  (wd_first),
    .expired(wd_expired)
  );

  // State, latched op kind and error-cause flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      kind_q <= OP_MULT;
      zero_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      zero_q <= zero_nxt;
      if (accept) kind_q <= bus.op_kind;
    end
  end

  // Next state: only the end signal matching the running kind is looked at;
  // zero-divisor beats div_end, and any end beats the watchdog.
  always_comb begin
    state_nxt = state;
    zero_nxt  = zero_q;
    accept    = 1'b0;
    wd_clr    = 1'b0;
    wd_en     = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.op_valid && bus.op_kind != OP_RSVD) begin
          accept    = 1'b1;
          wd_clr    = 1'b1;
          zero_nxt  = 1'b0;
          state_nxt = (bus.op_kind == OP_MULT) ? S_MULT_RUN : S_DIV_RUN;
        end
      end
      S_MULT_RUN: begin
        wd_en = 1'b1;
        if (bus.mult_end) state_nxt = S_WRITE;
        else if (wd_expired) begin
          state_nxt = S_ERR;
          zero_nxt  = 1'b0;
        end
      end
      S_DIV_RUN: begin
        wd_en = 1'b1;
        if (bus.div_0_exception) begin
          state_nxt = S_ERR;
          zero_nxt  = 1'b1;
        end else if (bus.div_end) state_nxt = S_WRITE;
        else if (wd_expired) begin
          state_nxt = S_ERR;
          zero_nxt  = 1'b0;
        end
      end
      S_WRITE: state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode: purely from registered state, so async reset clears outputs at once.
  logic in_run;
  assign in_run = (state == S_MULT_RUN) || (state == S_DIV_RUN);

  assign bus.op_ready     = (state == S_IDLE);
  assign bus.busy         = (state != S_IDLE);
  assign bus.mult_start   = (state == S_MULT_RUN) && wd_first;
  assign bus.div_start    = (state == S_DIV_RUN) && wd_first;
  assign bus.div_src      = (state != S_IDLE) && (kind_q == OP_DIVM);
  assign bus.div_or_mult  = (in_run || state == S_WRITE) && (kind_q == OP_MULT);
  assign bus.high_write   = (state == S_WRITE);
  assign bus.low_write    = (state == S_WRITE);
  assign bus.done         = (state == S_WRITE) || (state == S_ERR);
  assign bus.div_zero_err = (state == S_ERR) && zero_q;
  assign bus.timeout_err  = (state == S_ERR) && !zero_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: vector table of full operations plus
// hand-written handshake, held-request and mid-run reset sequences.
module tb_muldiv_sequencer;
  import muldiv_defs::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  muldiv_sequencer_if bus();

  muldiv_sequencer #(.TIMEOUT_CYCLES(40), .CNT_W(6)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [10:0] IDLE_OUTS = 11'b100_0000_0000;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [10:0] outs();
    return {bus.op_ready, bus.busy, bus.mult_start, bus.div_start, bus.div_src,
            bus.div_or_mult, bus.high_write, bus.low_write, bus.done,
            bus.div_zero_err, bus.timeout_err};
  endfunction

  task automatic clr_in();
    bus.op_valid = 1'b0; bus.op_kind = 2'b00;
    bus.mult_end = 1'b0; bus.div_end = 1'b0; bus.div_0_exception = 1'b0;
  endtask

  // One operation: accept in cycle 0, ends pulsed in given cycles (0 = never).
  typedef struct {
    string      nm;
    logic [1:0] kind;
    int         mend, dend, exc;
    int         done_cyc;
    bit         zero, tmo, wr, dom;
    int         src_cyc, ms, ds;
  } vec_t;

  task automatic run_vec(input vec_t v);
    int  done_c = -1;
    int  ms = 0, ds = 0, srcc = 0;
    logic zero = 0, tmo = 0, dom = 0;
    logic [1:0] wr = 0;
    @(posedge clock); #1;
    clr_in();
    bus.op_valid = 1'b1; bus.op_kind = v.kind;
    @(negedge clock);
    ms += int'(bus.mult_start); ds += int'(bus.div_start);
    for (int c = 1; c <= 60; c++) begin
      @(posedge clock); #1;
      bus.op_valid        = 1'b0;
      bus.mult_end        = (c == v.mend);
      bus.div_end         = (c == v.dend);
      bus.div_0_exception = (c == v.exc);
      @(negedge clock);
      ms   += int'(bus.mult_start);
      ds   += int'(bus.div_start);
      srcc += int'(bus.div_src);
      if (bus.done) begin
        done_c = c; zero = bus.div_zero_err; tmo = bus.timeout_err;
        wr = {bus.high_write, bus.low_write}; dom = bus.div_or_mult;
        break;
      end
    end
    chk({v.nm, " done_cycle"}, done_c, v.done_cyc);
    chk({v.nm, " zero_err"}, zero, v.zero);
    chk({v.nm, " timeout_err"}, tmo, v.tmo);
    chk({v.nm, " hi_lo_write"}, wr, v.wr ? 2'b11 : 2'b00);
    chk({v.nm, " div_or_mult"}, dom, v.dom);
    chk({v.nm, " div_src_cycles"}, srcc, v.src_cyc);
    chk({v.nm, " mult_starts"}, ms, v.ms);
    chk({v.nm, " div_starts"}, ds, v.ds);
    @(posedge clock); #1;
    clr_in();
    @(negedge clock);
    chk({v.nm, " idle_after"}, outs(), IDLE_OUTS);
  endtask

  vec_t vecs[9];

  initial begin
    int starts;
    clr_in();

    // Reset state
    #2;
    chk("reset_outs", outs(), IDLE_OUTS);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("post_reset_outs", outs(), IDLE_OUTS);

    //           name          kind  mend dend exc done zero tmo wr dom src ms ds
    vecs[0] = '{"mult",        OP_MULT, 33,  0,  0, 34, 0, 0, 1, 1,  0, 1, 0};
    vecs[1] = '{"div_zero",    OP_DIV,   0,  3,  3,  4, 1, 0, 0, 0,  0, 0, 1};
    vecs[2] = '{"mult_tmo",    OP_MULT,  0,  0,  0, 41, 0, 1, 0, 0,  0, 1, 0};
    vecs[3] = '{"divm",        OP_DIVM,  0, 20,  0, 21, 0, 0, 1, 0, 21, 0, 1};
    vecs[4] = '{"div_first",   OP_DIV,   0,  1,  0,  2, 0, 0, 1, 0,  0, 0, 1};
    vecs[5] = '{"mult_last",   OP_MULT, 40,  0,  0, 41, 0, 0, 1, 1,  0, 1, 0};
    vecs[6] = '{"mult_xend",   OP_MULT, 10,  5,  5, 11, 0, 0, 1, 1,  0, 1, 0};
    vecs[7] = '{"div_xend",    OP_DIV,   3,  7,  0,  8, 0, 0, 1, 0,  0, 0, 1};
    vecs[8] = '{"divm_tmo",    OP_DIVM,  0,  0,  0, 41, 0, 1, 0, 0, 41, 0, 1};

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reserved kind is never accepted
    starts = 0;
    @(posedge clock); #1;
    bus.op_valid = 1'b1; bus.op_kind = OP_RSVD;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      starts += int'(bus.mult_start) + int'(bus.div_start) + int'(bus.busy);
      @(posedge clock); #1;
    end
    @(negedge clock);
    chk("rsvd_no_start", starts, 0);
    chk("rsvd_ready", bus.op_ready, 1'b1);

    // Held request: MULT ends in cycle 3 (WRITE cycle 4); DIV held from cycle 2
    // is accepted at the end of IDLE cycle 5, so div_start appears in cycle 6.
    @(posedge clock); #1;
    clr_in(); bus.op_valid = 1'b1; bus.op_kind = OP_MULT;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clock); #1;
      bus.mult_end = (c == 3);
      bus.op_valid = (c >= 2);
      bus.op_kind  = (c >= 2) ? OP_DIV : OP_MULT;
      @(negedge clock);
      if (c == 4) chk("held_write_done", {bus.done, bus.high_write}, 2'b11);
      if (c == 5) chk("held_idle_gap", {bus.op_ready, bus.div_start}, 2'b10);
      if (c == 6) chk("held_div_start", {bus.busy, bus.div_start}, 2'b11);
    end
    @(posedge clock); #1;
    clr_in(); bus.div_end = 1'b1;
    @(negedge clock);
    chk("held_div_start_once", bus.div_start, 1'b0);
    @(posedge clock); #1;
    clr_in();
    @(negedge clock);
    chk("held_div_done", {bus.done, bus.high_write, bus.div_or_mult}, 3'b110);
    @(posedge clock); #1;

    // Reset asserted mid DIV_RUN: outputs drop immediately, no done afterwards.
    bus.op_valid = 1'b1; bus.op_kind = OP_DIVM;
    @(posedge clock); #1;
    clr_in();
    for (int c = 1; c < 10; c++) begin @(posedge clock); #1; end
    #2;
    chk("pre_reset_busy", {bus.busy, bus.div_src}, 2'b11);
    reset = 1'b0;
    #1;
    chk("reset_mid_outs", outs(), IDLE_OUTS);
    bus.div_end = 1'b1;
    @(posedge clock); #1;
    chk("reset_hold_outs", outs(), IDLE_OUTS);
    clr_in();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("reset_release_outs", outs(), IDLE_OUTS);

    // Normal MULT after reset
    begin
      vec_t v;
      v = '{"mult_after_rst", OP_MULT, 5, 0, 0, 6, 0, 0, 1, 1, 0, 1, 0};
      run_vec(v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
